pe_row_sequencer: RTL and testbench

PE_ROW_SEQUENCER -- requirements
Module: pe_row_sequencer

---
 rtl/pe_row_sequencer.sv | 125 ++++++++++++
 tb/tb_pe_row_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pe_row_sequencer.sv
// Sequences one row pass of a PE row: streams ifmap/filter operands out, captures
// the returned partial sums, then drains them through a valid/ready result port.
module pe_row_sequencer #(
  parameter int WIDTH   = 16,
  parameter int K       = 3,
  parameter int N_OUT   = 14,
  parameter int CAP_OFS = 4,
  localparam int N_IN   = N_OUT + K - 1,
  localparam int AW     = $clog2(N_IN)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  output logic               busy,
  output logic               done,
  input  logic               ld_valid,
  input  logic               ld_sel,
  input  logic [AW-1:0]      ld_addr,
  input  logic [WIDTH-1:0]   ld_data,
  output logic               ld_ready,
  output logic               pe_en,
  output logic [WIDTH-1:0]   pe_f,
  output logic [WIDTH-1:0]   pe_r,
  input  logic [2*WIDTH-1:0] pe_psum,
  output logic               o_valid,
  input  logic               o_ready,
  output logic [2*WIDTH-1:0] o_data,
  output logic [AW-1:0]      o_idx,
  output logic               o_last
);

  localparam int CW = $clog2(CAP_OFS + N_OUT);
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int RW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CAP_OFS + N_OUT - 1);

  // Handshakes: a load transfers on ld_valid && ld_ready; a result transfers on
  // o_valid && o_ready, and o_data/o_idx/o_last hold steady until that happens.
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt;
  logic [KW-1:0]       tap;
  logic [AW-1:0]       idx;
  logic [RW-1:0]       cap_j;
  logic                cap_en;
  logic [WIDTH-1:0]    fbuf [K];
  logic [WIDTH-1:0]    ibuf [N_IN];
  logic [2*WIDTH-1:0]  rbuf [N_OUT];

  assign cap_j  = RW'(cnt - CW'(CAP_OFS));
  assign cap_en = (state == RUN) && (cnt >= CW'(CAP_OFS)) && (cnt <= CNT_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == CNT_LAST) state_nxt = DRAIN;
      DRAIN:   if (o_ready && o_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    ld_ready = (state == IDLE);
    pe_en    = (state == RUN) && (cnt == '0);
    pe_f     = '0;
    pe_r     = '0;
    o_valid  = 1'b0;
    o_data   = '0;
    o_idx    = '0;
    o_last   = 1'b0;
    if (state == RUN && cnt < CW'(N_IN)) begin
      pe_f = ibuf[cnt[AW-1:0]];
      pe_r = fbuf[tap];
    end
    if (state == DRAIN) begin
      o_valid = 1'b1;
      o_data  = rbuf[idx[RW-1:0]];
      o_idx   = idx;
      o_last  = (idx == AW'(N_OUT - 1));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
      tap   <= '0;
      idx   <= '0;
      done  <= 1'b0;
      for (int i = 0; i < K; i++)     fbuf[i] <= '0;
      for (int i = 0; i < N_IN; i++)  ibuf[i] <= '0;
      for (int i = 0; i < N_OUT; i++) rbuf[i] <= '0;
    end else begin
      state <= state_nxt;
      done  <= (state == DRAIN) && o_ready && o_last;

      // tap tracks cnt mod K without a divider
      if (state == RUN && state_nxt == RUN) begin
        cnt <= cnt + 1'b1;
        tap <= (tap == KW'(K - 1)) ? '0 : tap + 1'b1;
      end else begin
        cnt <= '0;
        tap <= '0;
      end

      if (state == DRAIN) begin
        if (o_ready) idx <= o_last ? '0 : idx + 1'b1;
      end else begin
        idx <= '0;
      end

      if (cap_en) rbuf[cap_j] <= pe_psum;

      // Out-of-range addresses still complete the handshake but write nothing.
      if (ld_valid && state == IDLE) begin
        if (!ld_sel && ld_addr < AW'(K)) fbuf[ld_addr[KW-1:0]] <= ld_data;
        if (ld_sel && 32'(ld_addr) < N_IN) ibuf[ld_addr] <= ld_data;
      end
    end
  end

endmodule

// File: tb/tb_pe_row_sequencer.sv
// Directed bench for pe_row_sequencer: operand streaming, psum capture, result
// drain with back-pressure, load corner cases and reset abort.
module tb_pe_row_sequencer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        busy, done;
  logic        ld_valid = 1'b0;
  logic        ld_sel = 1'b0;
  logic [3:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic        ld_ready;
  logic        pe_en;
  logic [15:0] pe_f, pe_r;
  logic [31:0] pe_psum = '0;
  logic        o_valid;
  logic        o_ready = 1'b0;
  logic [31:0] o_data;
  logic [3:0]  o_idx;
  logic        o_last;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] fexp [3];
  logic [15:0] iexp [16];

  pe_row_sequencer dut (
    .clk(clk), .rstn(rstn), .start(start), .busy(busy), .done(done),
    .ld_valid(ld_valid), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_ready(ld_ready), .pe_en(pe_en), .pe_f(pe_f), .pe_r(pe_r),
    .pe_psum(pe_psum), .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
    .o_idx(o_idx), .o_last(o_last)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic load(input logic sel, input logic [3:0] addr, input logic [15:0] data);
    ld_valid = 1'b1; ld_sel = sel; ld_addr = addr; ld_data = data;
    @(posedge clk); #1;
    ld_valid = 1'b0;
  endtask

  // One full pass from IDLE; entered and left at 1 time unit after a rising edge.
  // ready_mode 0: o_ready held 1; 1: o_ready pattern 1,0,0 repeating.
  task automatic run_pass(input int ready_mode, input bit poke_start);
    int exp_idx;
    int cyc;
    logic [15:0] ef, er;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ld_valid = 1'b0;
    for (int c = 0; c < 18; c++) begin
      pe_psum = 32'(100 + c);
      start = poke_start && (c == 6);
      ef = (c < 16) ? iexp[c] : 16'h0;
      er = (c < 16) ? fexp[c % 3] : 16'h0;
      @(negedge clk);
      n_checks++;
      if (pe_en !== (c == 0)) begin
        n_fail++; $display("FAIL pe_en c=%0d: got %b expected %b", c, pe_en, (c == 0));
      end
      n_checks++;
      if (pe_f !== ef) begin
        n_fail++; $display("FAIL pe_f c=%0d: got %0d expected %0d", c, pe_f, ef);
      end
      n_checks++;
      if (pe_r !== er) begin
        n_fail++; $display("FAIL pe_r c=%0d: got %0d expected %0d", c, pe_r, er);
      end
      n_checks++;
      if ({busy, o_valid, ld_ready, done} !== 4'b1000) begin
        n_fail++; $display("FAIL run_flags c=%0d: got %b expected 1000", c, {busy, o_valid, ld_ready, done});
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    exp_idx = 0;
    cyc = 0;
    while (exp_idx < 14 && cyc < 100) begin
      o_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      @(negedge clk);
      n_checks++;
      if (o_valid !== 1'b1 || o_idx !== 4'(exp_idx)) begin
        n_fail++; $display("FAIL drain_idx: got valid=%b idx=%0d expected valid=1 idx=%0d", o_valid, o_idx, exp_idx);
      end
      n_checks++;
      if (o_data !== 32'(104 + exp_idx)) begin
        n_fail++; $display("FAIL drain_data idx=%0d: got %0d expected %0d", exp_idx, o_data, 104 + exp_idx);
      end
      n_checks++;
      if (o_last !== (exp_idx == 13) || done !== 1'b0) begin
        n_fail++; $display("FAIL drain_last idx=%0d: got last=%b done=%b expected last=%b done=0", exp_idx, o_last, done, (exp_idx == 13));
      end
      @(posedge clk); #1;
      if (o_ready) exp_idx++;
      cyc++;
    end
    o_ready = 1'b0;
    n_checks++;
    if (exp_idx != 14) begin
      n_fail++; $display("FAIL drain_budget: got %0d results expected 14", exp_idx);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || o_valid !== 1'b0) begin
      n_fail++; $display("FAIL done_pulse: got done=%b busy=%b valid=%b expected 1 0 0", done, busy, o_valid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL done_single: got done=%b busy=%b expected 0 0", done, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) fexp[i] = '0;
    for (int i = 0; i < 16; i++) iexp[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, done, pe_en, o_valid, o_last} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 00000", {busy, done, pe_en, o_valid, o_last});
    end
    n_checks++;
    if (pe_f !== 16'h0 || pe_r !== 16'h0 || o_data !== 32'h0 || o_idx !== 4'h0) begin
      n_fail++; $display("FAIL reset_data: got f=%0h r=%0h d=%0h i=%0h expected 0", pe_f, pe_r, o_data, o_idx);
    end
    rstn = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (ld_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ld_ready: got %b expected 1", ld_ready);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 3; i++) begin
      fexp[i] = 16'(i + 1);
      load(1'b0, 4'(i), fexp[i]);
    end
    for (int i = 0; i < 16; i++) begin
      iexp[i] = 16'(i + 1);
      load(1'b1, 4'(i), iexp[i]);
    end
    run_pass(0, 1'b0);
  endtask

  task automatic test_back_pressure();
    run_pass(1, 1'b0);
  endtask

  task automatic test_oob_load_and_ignored_start();
    ld_valid = 1'b1; ld_sel = 1'b0; ld_addr = 4'd5; ld_data = 16'h7;
    @(negedge clk);
    n_checks++;
    if (ld_ready !== 1'b1) begin
      n_fail++; $display("FAIL oob_ld_ready: got %b expected 1", ld_ready);
    end
    @(posedge clk); #1;
    ld_valid = 1'b0;
    run_pass(0, 1'b1);
  endtask

  task automatic test_load_with_start();
    iexp[0] = 16'd9;
    ld_valid = 1'b1; ld_sel = 1'b1; ld_addr = 4'd0; ld_data = 16'd9;
    run_pass(0, 1'b0);
  endtask

  task automatic test_reset_abort();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, pe_en, o_valid, o_last} !== 5'b0 || pe_f !== 16'h0 || pe_r !== 16'h0 || o_data !== 32'h0) begin
      n_fail++; $display("FAIL abort_outputs: got flags=%b f=%0h r=%0h d=%0h expected 0", {busy, done, pe_en, o_valid, o_last}, pe_f, pe_r, o_data);
    end
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) fexp[i] = '0;
    for (int i = 0; i < 16; i++) iexp[i] = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if ({busy, done, o_valid} !== 3'b000) begin
        n_fail++; $display("FAIL abort_quiet c=%0d: got %b expected 000", c, {busy, done, o_valid});
      end
    end
    @(posedge clk); #1;
    run_pass(0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_back_pressure();
    test_oob_load_and_ignored_start();
    test_load_with_start();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
